// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: sequencer states, ALU op
// codes and the record a requester posts.
package alu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_READ = 2'd2,
      S_ACK  = 2'd3
   } state_e;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_AND   = 2'b01;
   localparam logic [1:0] ALU_OP_XOR   = 2'b10;
   localparam logic [1:0] ALU_OP_SHIFT = 2'b11;

   // One posted operation as held until the ALU has executed it.
   typedef struct packed {
      logic [1:0] op;
      logic       sub;
      logic [7:0] a;
      logic [7:0] b;
   } alu_req_t;

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way arbiter: picks which pending requester gets the ALU next.
// Purely combinational; the round-robin pointer lives in the parent.
module alu_rr_arb2 #(
   parameter int P_FIXED_PRIO = 0
) (
   input  logic [1:0] pending_i,
   input  logic       ptr_i,
   output logic       gnt_valid_o,
   output logic       gnt_idx_o
);

   // Single requester wins outright; a tie goes to the pointer or to requester 0.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
      gnt_valid_o = |pending_i;
      gnt_idx_o   = 1'b0;
      case (pending_i)
         2'b01:   gnt_idx_o = 1'b0;
         2'b10:   gnt_idx_o = 1'b1;
         2'b11:   gnt_idx_o = (P_FIXED_PRIO != 0) ? 1'b0 : ptr_i;
         default: gnt_idx_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between the microcode sequencer (requester 0) and the
// address/increment unit (requester 1). Each posted operation is sequenced
// LOAD (operands on A and bus, Y write) -> READ (Y onto bus, sampled) -> ACK.
// All ALU control lines are registered so they change only on clock edges.
module alu_share_arb #(
   parameter int P_FIXED_PRIO = 0,
   parameter int P_RR_INIT    = 0
) (
   input  logic       i_clk,
   input  logic       i_nReset,
   input  logic       i_start0,
   input  logic [1:0] i_op0,
   input  logic       i_sub0,
   input  logic [7:0] i_a0,
   input  logic [7:0] i_b0,
   output logic       o_ack0,
   output logic [7:0] o_result0,
   input  logic       i_start1,
   input  logic [1:0] i_op1,
   input  logic       i_sub1,
   input  logic [7:0] i_a1,
   input  logic [7:0] i_b1,
   output logic       o_ack1,
   output logic [7:0] o_result1,
   output logic [7:0] o_aluA,
   output logic [7:0] o_busData,
   output logic       o_busOE,
   input  logic [7:0] i_busData,
   output logic       o_ctrlAluYNWE,
   output logic       o_ctrlAluNOE,
   output logic       o_ctrlAluSub,
   output logic [1:0] o_ctrlAluOp,
   output logic       o_busy,
   output logic       o_grant
);

   import alu_pkg::*;

   localparam logic PTR_INIT = (P_RR_INIT != 0);

   state_e     state_q, state_d;
   logic       grant_q, grant_d;
   logic       ptr_q, ptr_d;
   logic [1:0] pend_q, pend_d;
   alu_req_t   hold0_q, hold0_d;
   alu_req_t   hold1_q, hold1_d;

   logic [7:0] alu_a_q, alu_a_d;
   logic [7:0] bus_data_q, bus_data_d;
   logic       bus_oe_q, bus_oe_d;
   logic       ynwe_q, ynwe_d;
   logic       noe_q, noe_d;
   logic       alu_sub_q, alu_sub_d;
   logic [1:0] alu_op_q, alu_op_d;
   logic [1:0] ack_q, ack_d;
   logic [7:0] result0_q, result0_d;
   logic [7:0] result1_q, result1_d;

   logic       gnt_valid;
   logic       gnt_idx;
   alu_req_t   sel;

   alu_rr_arb2 #(
      .P_FIXED_PRIO(P_FIXED_PRIO)
   ) u_arb (
      .pending_i  (pend_q),
      .ptr_i      (ptr_q),
      .gnt_valid_o(gnt_valid),
      .gnt_idx_o  (gnt_idx)
   );

   // Next state, operand capture and the values the control registers take next.
   always_comb begin
      // NOTE: combinational logic uses blocking assignments so later lines see earlier results (pend_d below relies on it).
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      pend_d     = pend_q;
      hold0_d    = hold0_q;
      hold1_d    = hold1_q;
      alu_a_d    = alu_a_q;
      bus_data_d = bus_data_q;
      alu_sub_d  = alu_sub_q;
      alu_op_d   = alu_op_q;
      result0_d  = result0_q;
      result1_d  = result1_q;
      bus_oe_d   = 1'b0;
      ynwe_d     = 1'b1;
      noe_d      = 1'b1;
      ack_d      = 2'b00;
      sel        = gnt_idx ? hold1_q : hold0_q;

      // The ack cycle frees the served slot; a start in that same cycle refills it.
      if (state_q == S_ACK) pend_d[grant_q] = 1'b0;

      if (i_start0 && !pend_d[0]) begin
         pend_d[0] = 1'b1;
         hold0_d   = '{op: i_op0, sub: i_sub0, a: i_a0, b: i_b0};
      end
      if (i_start1 && !pend_d[1]) begin
         pend_d[1] = 1'b1;
         hold1_d   = '{op: i_op1, sub: i_sub1, a: i_a1, b: i_b1};
      end

      case (state_q)
         S_IDLE: begin
            if (gnt_valid) begin
               state_d    = S_LOAD;
               grant_d    = gnt_idx;
               alu_a_d    = sel.a;
               bus_data_d = sel.b;
               alu_op_d   = sel.op;
               alu_sub_d  = sel.sub;
               bus_oe_d   = 1'b1;
               ynwe_d     = 1'b0;
            end
         end
         S_LOAD: begin
            // Bus released and output enabled on the same edge: never both active.
            state_d = S_READ;
            noe_d   = 1'b0;
         end
         S_READ: begin
            state_d        = S_ACK;
            ack_d[grant_q] = 1'b1;
            if (grant_q) result1_d = i_busData;
            else         result0_d = i_busData;
         end
         S_ACK: begin
            state_d = S_IDLE;
            ptr_d   = ~grant_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, holding and output registers; reset aborts any operation in flight.
   always_ff @(posedge i_clk or negedge i_nReset) begin
      if (!i_nReset) begin
         state_q    <= S_IDLE;
         grant_q    <= 1'b0;
         ptr_q      <= PTR_INIT;
         pend_q     <= 2'b00;
         hold0_q    <= '0;
         hold1_q    <= '0;
         alu_a_q    <= 8'h00;
         bus_data_q <= 8'h00;
         bus_oe_q   <= 1'b0;
         ynwe_q     <= 1'b1;
         noe_q      <= 1'b1;
         alu_sub_q  <= 1'b0;
         alu_op_q   <= ALU_OP_ADD;
         ack_q      <= 2'b00;
         result0_q  <= 8'h00;
         result1_q  <= 8'h00;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         pend_q     <= pend_d;
         hold0_q    <= hold0_d;
         hold1_q    <= hold1_d;
         alu_a_q    <= alu_a_d;
         bus_data_q <= bus_data_d;
         bus_oe_q   <= bus_oe_d;
         ynwe_q     <= ynwe_d;
         noe_q      <= noe_d;
         alu_sub_q  <= alu_sub_d;
         alu_op_q   <= alu_op_d;
         ack_q      <= ack_d;
         result0_q  <= result0_d;
         result1_q  <= result1_d;
      end
   end

   assign o_ack0        = ack_q[0];
   assign o_ack1        = ack_q[1];
   assign o_result0     = result0_q;
   assign o_result1     = result1_q;
   assign o_aluA        = alu_a_q;
   assign o_busData     = bus_data_q;
   assign o_busOE       = bus_oe_q;
   assign o_ctrlAluYNWE = ynwe_q;
   assign o_ctrlAluNOE  = noe_q;
   assign o_ctrlAluSub  = alu_sub_q;
   assign o_ctrlAluOp   = alu_op_q;
   assign o_busy        = (state_q != S_IDLE);
   assign o_grant       = grant_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a round-robin instance and a fixed-priority
// instance share one stimulus; each has its own behavioural ALU attached.
module tb_alu_share_arb;
   import alu_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_nReset;
   logic       i_start0, i_sub0, i_start1, i_sub1;
   logic [1:0] i_op0, i_op1;
   logic [7:0] i_a0, i_b0, i_a1, i_b1;

   // round-robin instance
   logic       ack0, ack1, bus_oe, ynwe, noe, asub, busy, grant;
   logic [7:0] res0, res1, alu_a, bus_data, bus_in;
   logic [1:0] aop;
   // fixed-priority instance
   logic       ack0_f, ack1_f, bus_oe_f, ynwe_f, noe_f, asub_f, busy_f, grant_f;
   logic [7:0] res0_f, res1_f, alu_a_f, bus_data_f, bus_in_f;
   logic [1:0] aop_f;

   int n_chk = 0;
   int n_err = 0;
   int contention = 0;

   always #5 i_clk = ~i_clk;

   alu_share_arb #(.P_FIXED_PRIO(0), .P_RR_INIT(0)) dut (
      .i_clk(i_clk), .i_nReset(i_nReset),
      .i_start0(i_start0), .i_op0(i_op0), .i_sub0(i_sub0), .i_a0(i_a0), .i_b0(i_b0),
      .o_ack0(ack0), .o_result0(res0),
      .i_start1(i_start1), .i_op1(i_op1), .i_sub1(i_sub1), .i_a1(i_a1), .i_b1(i_b1),
      .o_ack1(ack1), .o_result1(res1),
      .o_aluA(alu_a), .o_busData(bus_data), .o_busOE(bus_oe), .i_busData(bus_in),
      .o_ctrlAluYNWE(ynwe), .o_ctrlAluNOE(noe), .o_ctrlAluSub(asub), .o_ctrlAluOp(aop),
      .o_busy(busy), .o_grant(grant)
   );

   alu_share_arb #(.P_FIXED_PRIO(1), .P_RR_INIT(0)) dut_fp (
      .i_clk(i_clk), .i_nReset(i_nReset),
      .i_start0(i_start0), .i_op0(i_op0), .i_sub0(i_sub0), .i_a0(i_a0), .i_b0(i_b0),
      .o_ack0(ack0_f), .o_result0(res0_f),
      .i_start1(i_start1), .i_op1(i_op1), .i_sub1(i_sub1), .i_a1(i_a1), .i_b1(i_b1),
      .o_ack1(ack1_f), .o_result1(res1_f),
      .o_aluA(alu_a_f), .o_busData(bus_data_f), .o_busOE(bus_oe_f), .i_busData(bus_in_f),
      .o_ctrlAluYNWE(ynwe_f), .o_ctrlAluNOE(noe_f), .o_ctrlAluSub(asub_f), .o_ctrlAluOp(aop_f),
      .o_busy(busy_f), .o_grant(grant_f)
   );

   // Behaviour of the external ALU: add/sub, and/xor with optional B invert,
   // shift right by b[2:0] (sub=0) or left (sub=1).
   function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic sub,
                                         input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      case (op)
         ALU_OP_ADD: r = sub ? a - b : a + b;
         ALU_OP_AND: r = a & (sub ? ~b : b);
         ALU_OP_XOR: r = a ^ (sub ? ~b : b);
         default:    r = sub ? (a << b[2:0]) : (a >> b[2:0]);
      endcase
      return r;
   endfunction

   logic [7:0] y_reg = 8'h00;
   logic [7:0] y_reg_f = 8'h00;
   always @(posedge i_clk) begin
      if (!ynwe)   y_reg   <= alu_fn(aop, asub, alu_a, bus_oe ? bus_data : 8'h00);
      if (!ynwe_f) y_reg_f <= alu_fn(aop_f, asub_f, alu_a_f, bus_oe_f ? bus_data_f : 8'h00);
   end
   assign bus_in   = noe   ? 8'hA5 : y_reg;
   assign bus_in_f = noe_f ? 8'hA5 : y_reg_f;

   always @(negedge i_clk) begin
      if (bus_oe && !noe)     contention++;
      if (bus_oe_f && !noe_f) contention++;
   end

   typedef struct {
      int         req;
      logic [1:0] op;
      logic       sub;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_starts();
      i_start0 = 1'b0;
      i_start1 = 1'b0;
   endtask

   task automatic post(input int req, input logic [1:0] op, input logic sub,
                       input logic [7:0] a, input logic [7:0] b);
      if (req == 0) begin
         i_start0 = 1'b1; i_op0 = op; i_sub0 = sub; i_a0 = a; i_b0 = b;
      end else begin
         i_start1 = 1'b1; i_op1 = op; i_sub1 = sub; i_a1 = a; i_b1 = b;
      end
   endtask

   task automatic do_reset();
      clear_starts();
      i_nReset = 1'b0;
      tick();
      tick();
      i_nReset = 1'b1;
      tick();
   endtask

   // Post one operation from an idle block and expect its ack after 4 cycles.
   task automatic run_vec(input vec_t v, input int idx);
      int lat = 0;
      logic [7:0] r = 8'h00;
      post(v.req, v.op, v.sub, v.a, v.b);
      for (int k = 1; k <= 12; k++) begin
         tick();
         clear_starts();
         if ((v.req == 0 && ack0) || (v.req == 1 && ack1)) begin
            lat = k;
            r = (v.req == 0) ? res0 : res1;
            break;
         end
      end
      check($sformatf("vec%0d_latency", idx), lat, 4);
      check($sformatf("vec%0d_result", idx), r, v.exp);
      tick();
   endtask

   // Both requesters saturated, each restarting in its own ack cycle with
   // random operands. Round-robin: acks alternate 0,1,0,... Fixed priority:
   // requester 0 takes 6 acks, then stops and requester 1 is served next.
   task automatic sat_test(input bit fp);
      logic [7:0] exp_res [2];
      logic [1:0] op;
      logic       sub;
      logic [7:0] a, b;
      int n_ack = 0;
      int last = 0;
      int total = fp ? 7 : 8;
      int idx, want;
      logic a0, a1;
      logic [7:0] r;
      do_reset();
      for (int q = 0; q < 2; q++) begin
         op = 2'($urandom_range(0, 3)); sub = 1'($urandom_range(0, 1));
         a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
         post(q, op, sub, a, b);
         exp_res[q] = alu_fn(op, sub, a, b);
      end
      for (int cyc = 1; cyc <= 80 && n_ack < total; cyc++) begin
         tick();
         clear_starts();
         a0 = fp ? ack0_f : ack0;
         a1 = fp ? ack1_f : ack1;
         if (a0 || a1) begin
            idx  = a1 ? 1 : 0;
            want = fp ? ((n_ack < 6) ? 0 : 1) : (n_ack % 2);
            r    = (idx == 1) ? (fp ? res1_f : res1) : (fp ? res0_f : res0);
            check(fp ? "fp_single_ack" : "rr_single_ack", {31'd0, a0 & a1}, 0);
            check(fp ? "fp_who" : "rr_who", idx, want);
            check(fp ? "fp_gap" : "rr_gap", cyc - last, 4);
            check(fp ? "fp_result" : "rr_result", r, exp_res[idx]);
            last = cyc;
            if (!fp || (idx == 0 && n_ack < 5)) begin
               op = 2'($urandom_range(0, 3)); sub = 1'($urandom_range(0, 1));
               a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
               post(idx, op, sub, a, b);
               exp_res[idx] = alu_fn(op, sub, a, b);
            end
            n_ack++;
         end
      end
      check(fp ? "fp_ack_count" : "rr_ack_count", n_ack, total);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, cnt;
      logic [7:0] r0, r1;

      vecs[0] = '{0, ALU_OP_ADD,   1'b0, 8'h12, 8'h34, 8'h46};
      vecs[1] = '{0, ALU_OP_SHIFT, 1'b0, 8'h80, 8'h03, 8'h10};
      vecs[2] = '{0, ALU_OP_SHIFT, 1'b1, 8'h01, 8'h03, 8'h08};
      vecs[3] = '{1, ALU_OP_XOR,   1'b0, 8'hF0, 8'h0F, 8'hFF};
      vecs[4] = '{1, ALU_OP_ADD,   1'b1, 8'h05, 8'h03, 8'h02};
      vecs[5] = '{0, ALU_OP_ADD,   1'b0, 8'hFF, 8'h01, 8'h00};
      vecs[6] = '{1, ALU_OP_AND,   1'b0, 8'hCC, 8'hAA, 8'h88};
      vecs[7] = '{0, ALU_OP_AND,   1'b1, 8'hCC, 8'hAA, 8'h44};
      vecs[8] = '{1, ALU_OP_XOR,   1'b1, 8'hF0, 8'h0F, 8'h00};

      i_op0 = 2'b00; i_sub0 = 1'b0; i_a0 = 8'h00; i_b0 = 8'h00;
      i_op1 = 2'b00; i_sub1 = 1'b0; i_a1 = 8'h00; i_b1 = 8'h00;
      clear_starts();
      i_nReset = 1'b0;
      tick();

      // reset values
      check("rst_ynwe", ynwe, 1);
      check("rst_noe", noe, 1);
      check("rst_busoe", bus_oe, 0);
      check("rst_sub_op", {asub, aop}, 0);
      check("rst_alua_busdata", {alu_a, bus_data}, 0);
      check("rst_acks", {ack0, ack1}, 0);
      check("rst_results", {res0, res1}, 0);
      check("rst_busy_grant", {busy, grant}, 0);
      i_nReset = 1'b1;
      tick();

      // single add walked through each phase
      post(0, ALU_OP_ADD, 1'b0, 8'h12, 8'h34);
      tick(); clear_starts();
      check("p1_idle_busy", busy, 0);
      tick();
      check("load_ynwe", ynwe, 0);
      check("load_alua", alu_a, 8'h12);
      check("load_busdata", bus_data, 8'h34);
      check("load_busoe_noe", {bus_oe, noe}, 2'b11);
      check("load_busy_grant_op", {busy, grant, aop}, 4'b1000);
      tick();
      check("read_noe_busoe_ynwe", {noe, bus_oe, ynwe}, 3'b001);
      check("read_no_ack", ack0, 0);
      tick();
      check("ack_ack0", ack0, 1);
      check("ack_result0", res0, 8'h46);
      check("ack_ctrl_idle", {ynwe, noe, bus_oe}, 3'b110);
      tick();
      check("post_ack_clear", {ack0, busy}, 0);
      check("post_ack_hold", res0, 8'h46);

      // table of single operations
      foreach (vecs[i]) run_vec(vecs[i], i);

      // simultaneous posts, requester 0 favoured first after reset
      do_reset();
      post(0, ALU_OP_ADD, 1'b1, 8'h05, 8'h03);
      post(1, ALU_OP_XOR, 1'b0, 8'hF0, 8'h0F);
      t0 = 0; t1 = 0; r0 = 8'h00; r1 = 8'h00;
      for (int k = 1; k <= 16; k++) begin
         tick(); clear_starts();
         if (ack0 && t0 == 0) begin t0 = k; r0 = res0; end
         if (ack1 && t1 == 0) begin t1 = k; r1 = res1; end
      end
      check("tie_ack0_cycle", t0, 4);
      check("tie_result0", r0, 8'h02);
      check("tie_ack1_cycle", t1, 8);
      check("tie_result1", r1, 8'hFF);

      // saturated requesters
      sat_test(1'b0);
      sat_test(1'b1);

      // a start while pending is ignored
      do_reset();
      post(0, ALU_OP_ADD, 1'b0, 8'h10, 8'h20);
      tick(); clear_starts();
      post(0, ALU_OP_XOR, 1'b0, 8'hFF, 8'h00);
      tick(); clear_starts();
      cnt = 0; t0 = 0; r0 = 8'h00;
      for (int k = 3; k <= 16; k++) begin
         tick();
         if (ack0) begin
            cnt++;
            if (t0 == 0) begin t0 = k; r0 = res0; end
         end
      end
      check("dup_ack_count", cnt, 1);
      check("dup_ack_cycle", t0, 4);
      check("dup_result", r0, 8'h30);

      // reset during READ aborts the operation
      do_reset();
      post(0, ALU_OP_ADD, 1'b0, 8'h11, 8'h22);
      tick(); clear_starts();
      tick();
      tick();
      check("abort_in_read", noe, 0);
      #2;
      i_nReset = 1'b0;
      #1;
      check("abort_ctrl_inactive", {ynwe, noe, bus_oe}, 3'b110);
      check("abort_busy_ack", {busy, ack0}, 0);
      tick();
      tick();
      i_nReset = 1'b1;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (ack0 || ack1) cnt++;
      end
      check("abort_no_ack", cnt, 0);
      run_vec(vecs[0], 100);

      check("bus_contention", contention, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
